seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_match_counter.sv | 35 +++
 rtl/seq_detect_param.sv | 128 ++++++++++++
 tb/tb_seq_detect_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the configurable serial pattern detector:
// FSM state encoding and default parameter values.
package seq_detect_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_PW = 8;
   localparam int DEF_LW = 4;
   localparam int DEF_CW = 8;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating up-counter for detected matches; CLR has priority over INC,
// and the count holds at all-ones instead of wrapping.
module seq_match_counter #(
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CLR,
   input  logic          INC,
   output logic [CW-1:0] CNT
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (INC && !(&cnt_q)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign CNT = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with run-time pattern/length/overlap configuration,
// registered one-cycle match pulse and saturating match count.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int PW = DEF_PW,
   parameter int LW = DEF_LW,
   parameter int CW = DEF_CW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN,
   input  logic          IN_VALID,
   input  logic          CFG_LOAD,
   input  logic [PW-1:0] PATTERN,
   input  logic [LW-1:0] LEN,
   input  logic          OVERLAP,
   output logic          MATCH,
   output logic [CW-1:0] MATCH_CNT,
   output logic          ARMED,
   output logic          CFG_ERR
);

   localparam logic [LW-1:0] PW_L = LW'(PW);

   state_t        state_q, state_d;
   logic [PW-1:0] hist_q, hist_d;
   logic [LW-1:0] fill_q, fill_d;
   logic [PW-1:0] pat_q, pat_d;
   logic [LW-1:0] len_q, len_d;
   logic          ovl_q, ovl_d;
   logic          match_q, match_d;
   logic          err_q, err_d;

   logic [PW-1:0] mask;
   logic [PW-1:0] hist_nxt;
   logic [LW-1:0] fill_inc;
   logic          cfg_legal;
   logic          hit;
   logic          cnt_clr;

   // Only the low len_q bits of history and pattern take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < PW; i++) begin
         mask[i] = (i < int'(len_q));
      end
   end

   assign hist_nxt  = {hist_q[PW-2:0], IN};
   assign fill_inc  = (fill_q >= PW_L) ? PW_L : fill_q + LW'(1);
   assign cfg_legal = (LEN != '0) && (LEN <= PW_L);
   assign hit       = (((hist_nxt ^ pat_q) & mask) == '0) && (fill_inc >= len_q);

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      err_d   = err_q;
      match_d = 1'b0;
      cnt_clr = 1'b0;
      // A configuration load wins over a same-cycle sample, which is dropped.
      if (CFG_LOAD) begin
         cnt_clr = 1'b1;
         hist_d  = '0;
         fill_d  = '0;
         if (cfg_legal) begin
            pat_d   = PATTERN;
            len_d   = LEN;
            ovl_d   = OVERLAP;
            err_d   = 1'b0;
            state_d = ST_RUN;
         end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end
      end else if (state_q == ST_RUN && IN_VALID) begin
         hist_d = hist_nxt;
         fill_d = fill_inc;
         if (hit) begin
            match_d = 1'b1;
            if (!ovl_q) begin
               fill_d = '0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         match_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         match_q <= match_d;
         err_q   <= err_d;
      end
   end

   seq_match_counter #(
      .CW (CW)
   ) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .CLR (cnt_clr),
      .INC (match_d),
      .CNT (MATCH_CNT)
   );

   assign MATCH   = match_q;
   assign ARMED   = (state_q == ST_RUN);
   assign CFG_ERR = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: expected MATCH/MATCH_CNT per driven
// cycle are queued at drive time and checked when the outputs settle.
module tb_seq_detect_param;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       IN = 1'b0;
   logic       IN_VALID = 1'b0;
   logic       CFG_LOAD = 1'b0;
   logic [7:0] PATTERN = '0;
   logic [3:0] LEN = '0;
   logic       OVERLAP = 1'b0;

   logic       MATCH, ARMED, CFG_ERR;
   logic [7:0] MATCH_CNT;
   logic       MATCH2, ARMED2, CFG_ERR2;
   logic [1:0] MATCH_CNT2;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       m;
      logic [7:0] c;
   } exp_t;
   exp_t exp_q[$];

   always #5 CLK = ~CLK;

   seq_detect_param #(.PW(8), .LW(4), .CW(8)) dut (
      .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .CFG_LOAD(CFG_LOAD),
      .PATTERN(PATTERN), .LEN(LEN), .OVERLAP(OVERLAP),
      .MATCH(MATCH), .MATCH_CNT(MATCH_CNT), .ARMED(ARMED), .CFG_ERR(CFG_ERR)
   );

   seq_detect_param #(.PW(8), .LW(4), .CW(2)) dut2 (
      .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .CFG_LOAD(CFG_LOAD),
      .PATTERN(PATTERN), .LEN(LEN), .OVERLAP(OVERLAP),
      .MATCH(MATCH2), .MATCH_CNT(MATCH_CNT2), .ARMED(ARMED2), .CFG_ERR(CFG_ERR2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; CFG_LOAD = 1'b0; IN_VALID = 1'b0;
      tick();
      RST = 1'b0;
      chk("rst_match", MATCH, 0);
      chk("rst_cnt", MATCH_CNT, 0);
      chk("rst_armed", ARMED, 0);
      chk("rst_err", CFG_ERR, 0);
   endtask

   task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic exp_armed, input logic exp_err);
      CFG_LOAD = 1'b1; PATTERN = pat; LEN = len; OVERLAP = ovl;
      tick();
      CFG_LOAD = 1'b0;
      chk("cfg_armed", ARMED, exp_armed);
      chk("cfg_err", CFG_ERR, exp_err);
      chk("cfg_cnt", MATCH_CNT, 0);
      chk("cfg_match", MATCH, 0);
   endtask

   task automatic step(input string tag, input logic b, input logic v,
                       input logic exp_m, input logic [7:0] exp_c);
      exp_t e;
      IN = b; IN_VALID = v;
      e.m = exp_m; e.c = exp_c;
      exp_q.push_back(e);
      tick();
      IN_VALID = 1'b0;
      e = exp_q.pop_front();
      chk({tag, "_match"}, MATCH, e.m);
      chk({tag, "_cnt"}, MATCH_CNT, e.c);
   endtask

   initial begin
      logic [7:0] s8;
      tick();
      do_reset();

      // 8-bit pattern, non-overlapping
      cfg(8'b00110011, 4'd8, 1'b0, 1'b1, 1'b0);
      s8 = 8'b00110011;
      for (int i = 7; i >= 0; i--) step("p8", s8[i], 1'b1, (i == 0), (i == 0) ? 8'd1 : 8'd0);
      step("p8_after", 1'b0, 1'b0, 1'b0, 8'd1);

      // 101 overlapping then non-overlapping
      cfg(8'b00000101, 4'd3, 1'b1, 1'b1, 1'b0);
      step("ov1_a", 1, 1, 0, 0);
      step("ov1_b", 0, 1, 0, 0);
      step("ov1_c", 1, 1, 1, 1);
      step("ov1_d", 0, 1, 0, 1);
      step("ov1_e", 1, 1, 1, 2);
      cfg(8'b00000101, 4'd3, 1'b0, 1'b1, 1'b0);
      step("ov0_a", 1, 1, 0, 0);
      step("ov0_b", 0, 1, 0, 0);
      step("ov0_c", 1, 1, 1, 1);
      step("ov0_d", 0, 1, 0, 1);
      step("ov0_e", 1, 1, 0, 1);

      // gaps with IN toggling while invalid; upper pattern bits are junk
      cfg(8'b11110101, 4'd3, 1'b0, 1'b1, 1'b0);
      step("gap_a", 1, 1, 0, 0);
      step("gap_i1", 0, 0, 0, 0);
      step("gap_i2", 1, 0, 0, 0);
      step("gap_b", 0, 1, 0, 0);
      step("gap_i3", 1, 0, 0, 0);
      step("gap_i4", 0, 0, 0, 0);
      step("gap_c", 1, 1, 1, 1);
      step("gap_i5", 1, 0, 0, 1);

      // illegal length, then a legal reload
      cfg(8'b00000101, 4'd0, 1'b1, 1'b0, 1'b1);
      step("ill_a", 1, 1, 0, 0);
      step("ill_b", 0, 1, 0, 0);
      step("ill_c", 1, 1, 0, 0);
      cfg(8'b00000101, 4'd9, 1'b1, 1'b0, 1'b1);
      cfg(8'b00000101, 4'd3, 1'b1, 1'b1, 1'b0);

      // load with a same-cycle valid sample: sample dropped, history cleared
      step("cl_a", 1, 1, 0, 0);
      step("cl_b", 0, 1, 0, 0);
      IN = 1'b1; IN_VALID = 1'b1;
      cfg(8'b00000101, 4'd3, 1'b1, 1'b1, 1'b0);
      step("cl_c", 1, 1, 0, 0);
      step("cl_d", 0, 1, 0, 0);
      step("cl_e", 1, 1, 1, 1);

      // reset mid-pattern, reload, finish the stream
      cfg(8'b00110011, 4'd8, 1'b0, 1'b1, 1'b0);
      step("rm_0", 0, 1, 0, 0);
      step("rm_1", 0, 1, 0, 0);
      step("rm_2", 1, 1, 0, 0);
      step("rm_3", 1, 1, 0, 0);
      step("rm_4", 0, 1, 0, 0);
      do_reset();
      step("rm_noarm", 1, 1, 0, 0);
      cfg(8'b00110011, 4'd8, 1'b0, 1'b1, 1'b0);
      step("rm_5", 0, 1, 0, 0);
      step("rm_6", 1, 1, 0, 0);
      step("rm_7", 1, 1, 0, 0);

      // 1-bit pattern; the CW=2 instance saturates at 3
      cfg(8'b00000001, 4'd1, 1'b1, 1'b1, 1'b0);
      chk("sat_cfg_cnt2", MATCH_CNT2, 0);
      for (int i = 0; i < 6; i++) begin
         step("sat", 1, 1, 1, 8'(i + 1));
         chk("sat_cnt2", MATCH_CNT2, (i < 3) ? i + 1 : 3);
         chk("sat_match2", MATCH2, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
